// File: rtl/io_mem_arbiter_pkg.sv
// Shared definitions for the two-master data-memory/I/O arbiter:
// FSM encoding, owner encoding, address-space decode.
package io_mem_arbiter_pkg;

   localparam int DATA_W      = 32;
   localparam int IO_ADDR_BIT = 7;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      RESP   = 2'b10
   } arb_state_e;

   typedef enum logic {
      OWNER_M0 = 1'b0,
      OWNER_M1 = 1'b1
   } owner_e;

   function automatic logic is_io(input logic [DATA_W-1:0] addr);
      return addr[IO_ADDR_BIT];
   endfunction

endpackage

// File: rtl/io_mem_arbiter_rr_arb2.sv
// Two-way tie-break: holds the last-served pointer and produces the
// combinational winner that the main FSM latches while in IDLE.
module rr_arb2
   import io_mem_arbiter_pkg::*;
#(
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic   clock,
   input  logic   resetn,
   input  logic   req0,
   input  logic   req1,
   input  logic   update,
   input  owner_e served,
   output owner_e winner
);

   // Reset to "m1 served last" so the first tie after reset goes to m0.
   owner_e last_served;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         last_served <= OWNER_M1;
      end else if (update) begin
         last_served <= served;
      end
   end

   always_comb begin
      winner = OWNER_M0;
      if (req0 && req1) begin
         if (FIXED_PRIO != 0) begin
            winner = OWNER_M0;
         end else begin
            winner = (last_served == OWNER_M1) ? OWNER_M0 : OWNER_M1;
         end
      end else if (req1) begin
         winner = OWNER_M1;
      end
   end

endmodule

// File: rtl/io_mem_arbiter.sv
// Arbitrates two masters onto one data-memory/I/O port with a three-state
// IDLE/ACCESS/RESP sequence; m1 can be barred from the I/O space.
module io_mem_arbiter
   import io_mem_arbiter_pkg::*;
#(
   parameter int unsigned FIXED_PRIO = 0,
   parameter int unsigned M1_IO_EN   = 1
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              m0_req,
   input  logic              m1_req,
   input  logic [DATA_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic              m0_we,
   input  logic              m1_we,
   output logic              m0_gnt,
   output logic              m1_gnt,
   output logic              m0_done,
   output logic              m1_done,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_err,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_is_io,
   output arb_state_e        fsm_state
);

   arb_state_e state;
   owner_e     owner;
   owner_e     winner;
   logic       refused;
   logic       m1_refuse;
   logic       arb_update;

   assign m1_refuse  = (M1_IO_EN == 0) && is_io(m1_addr);
   assign arb_update = (state == RESP);
   assign mem_is_io  = is_io(mem_addr);
   assign fsm_state  = state;

   rr_arb2 #(
      .FIXED_PRIO (FIXED_PRIO)
   ) u_rr_arb2 (
      .clock  (clock),
      .resetn (resetn),
      .req0   (m0_req),
      .req1   (m1_req),
      .update (arb_update),
      .served (owner),
      .winner (winner)
   );

   // The memory-side address/data/we are registered on entry to ACCESS, so
   // the owner's request is frozen for the whole access.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         owner     <= OWNER_M0;
         refused   <= 1'b0;
         m0_gnt    <= 1'b0;
         m1_gnt    <= 1'b0;
         m0_done   <= 1'b0;
         m1_done   <= 1'b0;
         m1_err    <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (m0_req || m1_req) begin
                  state <= ACCESS;
                  owner <= winner;
                  if (winner == OWNER_M1) begin
                     m1_gnt    <= 1'b1;
                     mem_addr  <= m1_addr;
                     mem_wdata <= m1_wdata;
                     mem_we    <= m1_we && !m1_refuse;
                     refused   <= m1_refuse;
                  end else begin
                     m0_gnt    <= 1'b1;
                     mem_addr  <= m0_addr;
                     mem_wdata <= m0_wdata;
                     mem_we    <= m0_we;
                     refused   <= 1'b0;
                  end
               end
            end
            ACCESS: begin
               state  <= RESP;
               mem_we <= 1'b0;
               if (owner == OWNER_M1) begin
                  m1_done <= 1'b1;
                  m1_err  <= refused;
                  if (!refused) begin
                     m1_rdata <= mem_rdata;
                  end
               end else begin
                  m0_done  <= 1'b1;
                  m0_rdata <= mem_rdata;
               end
            end
            RESP: begin
               state   <= IDLE;
               m0_gnt  <= 1'b0;
               m1_gnt  <= 1'b0;
               m0_done <= 1'b0;
               m1_done <= 1'b0;
               m1_err  <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   a_gnt_exclusive: assert property (@(posedge clock) disable iff (!resetn)
      !(m0_gnt && m1_gnt));

   a_we_in_access: assert property (@(posedge clock) disable iff (!resetn)
      mem_we |-> (state == ACCESS));

endmodule

// File: tb/tb_io_mem_arbiter.sv
// Directed bench for io_mem_arbiter: three instances (round-robin, fixed
// priority, m1 barred from I/O) share one stimulus stream.
module tb_io_mem_arbiter;
   import io_mem_arbiter_pkg::*;

   localparam int N_DUT = 3;   // 0: round-robin, 1: fixed priority, 2: m1 I/O refused

   logic        clock = 1'b0;
   logic        resetn = 1'b1;
   logic        m0_req, m1_req, m0_we, m1_we;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, mem_rdata;

   logic        m0_gnt [N_DUT];
   logic        m1_gnt [N_DUT];
   logic        m0_done [N_DUT];
   logic        m1_done [N_DUT];
   logic        m1_err [N_DUT];
   logic        mem_we [N_DUT];
   logic        mem_is_io [N_DUT];
   logic [31:0] m0_rdata [N_DUT];
   logic [31:0] m1_rdata [N_DUT];
   logic [31:0] mem_addr [N_DUT];
   logic [31:0] mem_wdata [N_DUT];
   arb_state_e  fsm_state [N_DUT];

   int          n_checks = 0;
   int          n_pass = 0;
   logic [0:0]  exp_q[$];

   always #5 clock = ~clock;

   for (genvar g = 0; g < N_DUT; g++) begin : g_dut
      io_mem_arbiter #(
         .FIXED_PRIO ((g == 1) ? 1 : 0),
         .M1_IO_EN   ((g == 2) ? 0 : 1)
      ) dut (
         .clock     (clock),
         .resetn    (resetn),
         .m0_req    (m0_req),
         .m1_req    (m1_req),
         .m0_addr   (m0_addr),
         .m1_addr   (m1_addr),
         .m0_wdata  (m0_wdata),
         .m1_wdata  (m1_wdata),
         .m0_we     (m0_we),
         .m1_we     (m1_we),
         .m0_gnt    (m0_gnt[g]),
         .m1_gnt    (m1_gnt[g]),
         .m0_done   (m0_done[g]),
         .m1_done   (m1_done[g]),
         .m0_rdata  (m0_rdata[g]),
         .m1_rdata  (m1_rdata[g]),
         .m1_err    (m1_err[g]),
         .mem_addr  (mem_addr[g]),
         .mem_wdata (mem_wdata[g]),
         .mem_we    (mem_we[g]),
         .mem_rdata (mem_rdata),
         .mem_is_io (mem_is_io[g]),
         .fsm_state (fsm_state[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
      m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
      mem_rdata = '0;
   endtask

   // Returns just after a rising edge with resetn freshly released, so the
   // next rising edge is the first arbitration.
   task automatic apply_reset();
      resetn = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clock);
      #1 resetn = 1'b1;
   endtask

   // One cycle of a back-to-back stream: ph 0 = ACCESS, 1 = RESP, 2 = IDLE.
   task automatic check_slot(input int d, input int c, input int ph, input logic own,
                             input logic [31:0] exp_addr, input logic exp_we);
      string t;
      t = $sformatf("stream d%0d c%0d", d, c);
      check({t, " m0_gnt"}, m0_gnt[d], (ph < 2) && !own);
      check({t, " m1_gnt"}, m1_gnt[d], (ph < 2) && own);
      check({t, " m0_done"}, m0_done[d], (ph == 1) && !own);
      check({t, " m1_done"}, m1_done[d], (ph == 1) && own);
      check({t, " mem_we"}, mem_we[d], (ph == 0) && exp_we);
      if (ph == 0) check({t, " mem_addr"}, mem_addr[d], exp_addr);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         ph;
      logic       own;
      logic [0:0] rr_owner;

      idle_inputs();
      #2 resetn = 1'b0;
      #2;
      // Asynchronous reset values, before any clock edge.
      for (int d = 0; d < N_DUT; d++) begin
         check($sformatf("rst d%0d state", d), 32'(fsm_state[d]), 32'(IDLE));
         check($sformatf("rst d%0d gnt", d), {m0_gnt[d], m1_gnt[d]}, 0);
         check($sformatf("rst d%0d done_err", d), {m0_done[d], m1_done[d], m1_err[d]}, 0);
         check($sformatf("rst d%0d mem_we", d), mem_we[d], 0);
         check($sformatf("rst d%0d mem_addr", d), mem_addr[d], 0);
         check($sformatf("rst d%0d mem_wdata", d), mem_wdata[d], 0);
         check($sformatf("rst d%0d m0_rdata", d), m0_rdata[d], 0);
         check($sformatf("rst d%0d m1_rdata", d), m1_rdata[d], 0);
      end

      // m0 single read of 0x04.
      apply_reset();
      m0_req = 1'b1; m0_addr = 32'h04; mem_rdata = 32'h1234_5678;
      tick();
      for (int d = 0; d < N_DUT; d++) begin
         check($sformatf("rd d%0d c1 state", d), 32'(fsm_state[d]), 32'(ACCESS));
         check($sformatf("rd d%0d c1 m0_gnt", d), m0_gnt[d], 1);
         check($sformatf("rd d%0d c1 m0_done", d), m0_done[d], 0);
         check($sformatf("rd d%0d c1 mem_addr", d), mem_addr[d], 32'h04);
         check($sformatf("rd d%0d c1 mem_we", d), mem_we[d], 0);
      end
      tick();
      m0_req = 1'b0;
      for (int d = 0; d < N_DUT; d++) begin
         check($sformatf("rd d%0d c2 m0_gnt", d), m0_gnt[d], 1);
         check($sformatf("rd d%0d c2 m0_done", d), m0_done[d], 1);
         check($sformatf("rd d%0d c2 m0_rdata", d), m0_rdata[d], 32'h1234_5678);
         check($sformatf("rd d%0d c2 m1_rdata", d), m1_rdata[d], 0);
         check($sformatf("rd d%0d c2 mem_we", d), mem_we[d], 0);
      end
      tick();
      for (int d = 0; d < N_DUT; d++) begin
         check($sformatf("rd d%0d c3 state", d), 32'(fsm_state[d]), 32'(IDLE));
         check($sformatf("rd d%0d c3 gnt_done", d), {m0_gnt[d], m0_done[d]}, 0);
      end

      // Both masters write continuously: RR alternates m0,m1,m0,m1; fixed gives m0 x4.
      apply_reset();
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hA0A0_A0A0;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'hB1B1_B1B1;
      exp_q = {};
      exp_q.push_back(1'b0); exp_q.push_back(1'b1);
      exp_q.push_back(1'b0); exp_q.push_back(1'b1);
      rr_owner = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         tick();
         ph = (c - 1) % 3;
         if (ph == 0) rr_owner = exp_q.pop_front();
         for (int d = 0; d < N_DUT; d++) begin
            own = (d == 1) ? 1'b0 : rr_owner[0];
            check_slot(d, c, ph, own, own ? 32'h20 : 32'h10, 1'b1);
            if (ph == 0) check($sformatf("stream d%0d c%0d mem_wdata", d, c), mem_wdata[d],
                               own ? 32'hB1B1_B1B1 : 32'hA0A0_A0A0);
         end
         if (c == 12) begin
            m0_req = 1'b0; m1_req = 1'b0;
         end
      end

      // m1 writes 0xDEADBEEF to I/O address 0x80.
      apply_reset();
      mem_rdata = 32'h5555_AAAA;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h80; m1_wdata = 32'hDEAD_BEEF;
      tick();
      for (int d = 0; d < N_DUT; d++) begin
         check($sformatf("io d%0d c1 m1_gnt", d), m1_gnt[d], 1);
         check($sformatf("io d%0d c1 mem_is_io", d), mem_is_io[d], 1);
         check($sformatf("io d%0d c1 mem_addr", d), mem_addr[d], 32'h80);
         check($sformatf("io d%0d c1 mem_we", d), mem_we[d], (d == 2) ? 0 : 1);
      end
      tick();
      m1_req = 1'b0;
      for (int d = 0; d < N_DUT; d++) begin
         check($sformatf("io d%0d c2 m1_done", d), m1_done[d], 1);
         check($sformatf("io d%0d c2 m1_err", d), m1_err[d], (d == 2) ? 1 : 0);
         check($sformatf("io d%0d c2 m1_rdata", d), m1_rdata[d], (d == 2) ? 32'h0 : 32'h5555_AAAA);
         check($sformatf("io d%0d c2 m0_rdata", d), m0_rdata[d], 0);
         check($sformatf("io d%0d c2 mem_we", d), mem_we[d], 0);
      end
      tick();
      for (int d = 0; d < N_DUT; d++) begin
         check($sformatf("io d%0d c3 done_err", d), {m1_done[d], m1_err[d]}, 0);
      end

      // Tie with m0 read vs m1 I/O write: a refused m1 still counts as served.
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h04;
      m1_req = 1'b1;
      exp_q = {};
      exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
      for (int c = 1; c <= 9; c++) begin
         tick();
         ph = (c - 1) % 3;
         if (ph == 0) rr_owner = exp_q.pop_front();
         for (int d = 0; d < N_DUT; d++) begin
            own = (d == 1) ? 1'b0 : rr_owner[0];
            check_slot(d, c + 100, ph, own, own ? 32'h80 : 32'h04, own && (d != 2));
            if (ph == 1 && own)
               check($sformatf("io tie d%0d c%0d m1_err", d, c), m1_err[d], (d == 2) ? 1 : 0);
         end
         if (c == 9) begin
            m0_req = 1'b0; m1_req = 1'b0;
         end
      end

      // Reset pulsed during ACCESS of an m1 write.
      apply_reset();
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h30; m1_wdata = 32'h1111_2222;
      tick();
      for (int d = 0; d < N_DUT; d++) begin
         check($sformatf("ra d%0d access m1_gnt", d), m1_gnt[d], 1);
         check($sformatf("ra d%0d access mem_we", d), mem_we[d], 1);
      end
      #2 resetn = 1'b0; m1_req = 1'b0;
      #1;
      for (int d = 0; d < N_DUT; d++) begin
         check($sformatf("ra d%0d state", d), 32'(fsm_state[d]), 32'(IDLE));
         check($sformatf("ra d%0d gnt", d), {m0_gnt[d], m1_gnt[d]}, 0);
         check($sformatf("ra d%0d mem_we", d), mem_we[d], 0);
         check($sformatf("ra d%0d mem_addr", d), mem_addr[d], 0);
         check($sformatf("ra d%0d mem_wdata", d), mem_wdata[d], 0);
         check($sformatf("ra d%0d m1_done", d), m1_done[d], 0);
      end
      tick();
      for (int d = 0; d < N_DUT; d++) begin
         check($sformatf("ra d%0d held m1_done", d), m1_done[d], 0);
      end
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h04;
      m1_req = 1'b1;
      resetn = 1'b1;
      tick();
      for (int d = 0; d < N_DUT; d++) begin
         check($sformatf("ra d%0d tie state", d), 32'(fsm_state[d]), 32'(ACCESS));
         check($sformatf("ra d%0d tie m0_gnt", d), m0_gnt[d], 1);
         check($sformatf("ra d%0d tie m1_gnt", d), m1_gnt[d], 0);
      end

      // m0 drops req in ACCESS, then holds req across done.
      apply_reset();
      m0_req = 1'b1; m0_addr = 32'h08; mem_rdata = 32'hCAFE_0001;
      tick();
      m0_req = 1'b0;
      tick();
      for (int d = 0; d < N_DUT; d++) begin
         check($sformatf("drop d%0d m0_done", d), m0_done[d], 1);
         check($sformatf("drop d%0d m0_rdata", d), m0_rdata[d], 32'hCAFE_0001);
      end
      tick();
      tick();
      for (int d = 0; d < N_DUT; d++) begin
         check($sformatf("drop d%0d idle state", d), 32'(fsm_state[d]), 32'(IDLE));
         check($sformatf("drop d%0d idle m0_gnt", d), m0_gnt[d], 0);
      end
      m0_req = 1'b1;
      tick();
      tick();
      for (int d = 0; d < N_DUT; d++) begin
         check($sformatf("hold d%0d m0_done", d), m0_done[d], 1);
      end
      tick();
      for (int d = 0; d < N_DUT; d++) begin
         check($sformatf("hold d%0d done+1 state", d), 32'(fsm_state[d]), 32'(IDLE));
         check($sformatf("hold d%0d done+1 m0_gnt", d), m0_gnt[d], 0);
      end
      tick();
      for (int d = 0; d < N_DUT; d++) begin
         check($sformatf("hold d%0d done+2 state", d), 32'(fsm_state[d]), 32'(ACCESS));
         check($sformatf("hold d%0d done+2 m0_gnt", d), m0_gnt[d], 1);
      end
      m0_req = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/io_mem_arbiter.md
IO_MEM_ARBITER -- requirements
Module: io_mem_arbiter

Interface
REQ-001 The module SHALL have parameter FIXED_PRIO, default 0, which selects the arbitration policy: 0 = round-robin, 1 = m0 always wins.
REQ-002 The module SHALL have parameter M1_IO_EN, default 1, which controls m1 I/O access: 0 = m1 access to I/O space (addr[7]=1) is refused with an error.
REQ-003 The module SHALL have the following ports, clock and reset first:
- clock  in  1  single system clock; all state is updated on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- m0_req, m1_req  in  1 each  request; held high until the matching done.
- m0_addr, m1_addr  in  32 each  byte address.
- m0_wdata, m1_wdata  in  32 each  write data.
- m0_we, m1_we  in  1 each  write strobe; 0 = read.
- m0_gnt, m1_gnt  out  1 each  high while the master owns the memory port.
- m0_done, m1_done  out  1 each  one-cycle completion pulse.
- m0_rdata, m1_rdata  out  32 each  registered read data.
- m1_err  out  1  completion was refused; valid with m1_done.
- mem_addr  out  32  address to the data-memory/I/O block.
- mem_wdata  out  32  write data to the data-memory/I/O block.
- mem_we  out  1  write enable to the data-memory/I/O block.
- mem_rdata  in  32  read data from the data-memory/I/O block.
- mem_is_io  out  1  equals mem_addr[7].

Function
REQ-004 The FSM SHALL have three states: IDLE, ACCESS and RESP; IDLE->ACCESS when any req is high; ACCESS->RESP always; RESP->IDLE always.
REQ-005 In IDLE the arbiter SHALL latch the owner: with one request, that master wins; with both requests, FIXED_PRIO=1 gives m0 and FIXED_PRIO=0 gives the master not served last.
REQ-006 The round-robin pointer SHALL update only on a completed transaction; refused transactions also count as served.
REQ-007 gnt SHALL be high for the owner in ACCESS and RESP only, never for both masters at once.
REQ-008 In ACCESS, mem_addr, mem_wdata and mem_we SHALL come from the owner; outside ACCESS mem_we=0 and mem_addr and mem_wdata hold their last values.
REQ-009 mem_rdata SHALL be captured into the owner's rdata at the rising edge that ends ACCESS; the non-owner's rdata holds.
REQ-010 The owner's done SHALL pulse for exactly the RESP cycle.
REQ-011 Latency: req seen high in IDLE at edge n gives ACCESS in cycle n+1 and done in cycle n+2; minimum spacing is 3 cycles per transaction.
REQ-012 If m1 owns the port, M1_IO_EN=0 and m1_addr[7]=1, then mem_we SHALL stay 0 in ACCESS, m1_rdata SHALL hold, and m1_err SHALL be 1 with m1_done.
REQ-013 A req dropped before done SHALL NOT abort the transaction: it completes and done pulses.
REQ-014 A req held high after done SHALL be treated as a new request in the next IDLE.
REQ-015 Owner inputs changing during ACCESS are a protocol violation; the values sampled in ACCESS are used.

Reset
REQ-016 resetn low SHALL asynchronously force the following values: state=IDLE, gnt=0, done=0, m1_err=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, and the round-robin pointer so that m0 wins the first tie.
REQ-017 A reset in ACCESS or RESP SHALL drop the transaction with no done pulse; the write has no effect if reset is asserted before the edge ending ACCESS.
REQ-018 The first arbitration after reset release SHALL occur at the first rising edge with resetn high.

Structure
REQ-019 A shared package SHALL hold the state encoding (IDLE=2'b00, ACCESS=2'b01, RESP=2'b10) and IO_ADDR_BIT=7.
REQ-020 The tie-break SHALL be a sub-module rr_arb2, containing the pointer register and the 2-way grant logic; the FSM and datapath stay in io_mem_arbiter.

Verification
REQ-021 m0 read only, addr 0x04, mem_rdata=0x12345678 -> m0_gnt in cycles 1-2, m0_done in cycle 2, m0_rdata=0x12345678, mem_we=0 throughout.
REQ-022 Both masters request writes with FIXED_PRIO=0 after reset -> m0 is served first (mem_we=1 one cycle, addr m0_addr), then m1 three cycles later; a third tie goes to m0.
REQ-023 FIXED_PRIO=1 with both reqs held for 4 transactions -> m0 gets all 4 grants and m1 never gets gnt.
REQ-024 M1_IO_EN=0, m1 writes addr 0x80 data 0xDEADBEEF -> mem_we stays 0, m1_done=1 and m1_err=1, m1_rdata unchanged, mem_is_io=1 in ACCESS.
REQ-025 resetn pulsed low during ACCESS of an m1 write -> no m1_done, all outputs at reset values immediately, and the next tie goes to m0.
REQ-026 m0 drops req in ACCESS -> m0_done still pulses and no new grant follows; m0 holding req after done -> new ACCESS at done+2.
